// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared types, constants and select-code helper for the mux scan controller
package mux_scan_pkg;

    localparam int N_SRC = 9;
    localparam int SEL_W = 4;
    localparam logic [SEL_W-1:0] SEL_IDLE = 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        GAP
    } state_t;

    // Requester index k drives mux select code k+1; code 0 is reserved for "no source".
    function automatic logic [SEL_W-1:0] idx_to_sel(input logic [SEL_W-1:0] k);
        return k + 4'd1;
    endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// rtl/mux_scan_ctrl_if.sv - requester/select bundle of the mux scan controller (MUX_SCAN_CAPTURE_EN adds capture signals)
interface mux_scan_ctrl_if #(
    parameter int DWELL_W = 4
);
    import mux_scan_pkg::*;

    logic               ena;
    logic [N_SRC-1:0]   req;
    logic [DWELL_W-1:0] dwell;
    logic               early_release;
    logic [SEL_W-1:0]   sel;
    logic [N_SRC-1:0]   grant;
    logic               busy;
    logic               last;
`ifdef MUX_SCAN_CAPTURE_EN
    logic               mux_bit;
    logic [N_SRC-1:0]   captured;
    logic               cap_valid;
`endif

`ifdef MUX_SCAN_CAPTURE_EN
    modport master (
        output ena, req, dwell, early_release, mux_bit,
        input  sel, grant, busy, last, captured, cap_valid
    );
    modport slave (
        input  ena, req, dwell, early_release, mux_bit,
        output sel, grant, busy, last, captured, cap_valid
    );
`else
    modport master (
        output ena, req, dwell, early_release,
        input  sel, grant, busy, last
    );
    modport slave (
        input  ena, req, dwell, early_release,
        output sel, grant, busy, last
    );
`endif

endinterface

// File: rtl/rr_pick9.sv
// rtl/rr_pick9.sv - combinational round-robin search over nine requests, wrapping at 9
module rr_pick9
    import mux_scan_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [4:0] pos;

    // Walk offsets from the far end back to ptr so the nearest set request wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            pos = {1'b0, ptr} + 5'(i);
            if (pos >= 5'(N_SRC)) begin
                pos = pos - 5'(N_SRC);
            end
            if (req[pos[3:0]]) begin
                found = 1'b1;
                idx   = pos[3:0];
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - round-robin select scheduler for the 9-input bit mux (optional MUX_SCAN_CAPTURE_EN)
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_scan_ctrl_if.slave bus
);

    state_t             state, state_n;
    logic [SEL_W-1:0]   cur, cur_n;
    logic [SEL_W-1:0]   ptr, ptr_n;
    logic [SEL_W-1:0]   sel_q, sel_n;
    logic [N_SRC-1:0]   grant_q, grant_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic               hold_exit;
    logic               found;
    logic [SEL_W-1:0]   pick_idx;

    rr_pick9 u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .found (found),
        .idx   (pick_idx)
    );

    // State and output registers; reset may land mid-grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur     <= '0;
            ptr     <= '0;
            cnt     <= '0;
            sel_q   <= SEL_IDLE;
            grant_q <= '0;
        end else begin
            state   <= state_n;
            cur     <= cur_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            sel_q   <= sel_n;
            grant_q <= grant_n;
        end
    end

    // Next state: pick in IDLE, hold until any exit cause, then one break-before-make GAP.
    always_comb begin
        state_n   = state;
        cur_n     = cur;
        ptr_n     = ptr;
        cnt_n     = cnt;
        sel_n     = SEL_IDLE;
        grant_n   = '0;
        hold_exit = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ena && found) begin
                    state_n = HOLD;
                    cur_n   = pick_idx;
                    cnt_n   = bus.dwell;
                    sel_n   = idx_to_sel(pick_idx);
                    grant_n = N_SRC'(1) << pick_idx;
                end
            end
            HOLD: begin
                hold_exit = (cnt == '0) || !bus.req[cur] || bus.early_release || !bus.ena;
                if (hold_exit) begin
                    state_n = GAP;
                end else begin
                    cnt_n   = cnt - DWELL_W'(1);
                    sel_n   = sel_q;
                    grant_n = grant_q;
                end
            end
            GAP: begin
                state_n = IDLE;
                ptr_n   = (cur == 4'(N_SRC - 1)) ? '0 : cur + 4'd1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.sel   = sel_q;
    assign bus.grant = grant_q;
    assign bus.busy  = (state != IDLE);
    assign bus.last  = hold_exit;

`ifdef MUX_SCAN_CAPTURE_EN
    logic [N_SRC-1:0] captured_q;
    logic             cap_valid_q;

    // Latch the mux output for the current owner on its final hold cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            captured_q  <= '0;
            cap_valid_q <= 1'b0;
        end else begin
            cap_valid_q <= hold_exit;
            if (hold_exit) begin
                captured_q[cur] <= bus.mux_bit;
            end
        end
    end

    assign bus.captured  = captured_q;
    assign bus.cap_valid = cap_valid_q;
`endif

endmodule
